// File: rtl/zap_branch_pkg.sv
// Shared encodings for the branch pre-decode / early-redirect stage.
package zap_branch_pkg;

  // 2-bit branch predictor counter states.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bstate_t;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } fsm_state_t;

  localparam logic [3:0] COND_AL   = 4'b1110;
  localparam logic [3:0] COND_NV   = 4'b1111;
  localparam logic [2:0] BR_OPCODE = 3'b101;

endpackage

// File: rtl/zap_branch_redirect_if.sv
// Instruction bus from the branch predictor and the registered bus toward decode.
// With ZAP_BRANCH_REDIRECT_STATS_EN defined, this also carries the redirect counter.
interface zap_branch_redirect_if;
  logic        i_cpsr_t;
  logic [31:0] i_inst;
  logic        i_val;
  logic        i_abt;
  logic [31:0] i_pc_plus_8;
  logic [1:0]  i_bstate;

  logic [31:0] o_inst_ff;
  logic        o_val_ff;
  logic        o_abt_ff;
  logic [31:0] o_pc_plus_8_ff;
  logic        o_taken_ff;
  logic        o_clear_from_decode;
  logic [31:0] o_pc_from_decode;
`ifdef ZAP_BRANCH_REDIRECT_STATS_EN
  logic [31:0] o_redirect_count;
`endif

  modport master (
    output i_cpsr_t, i_inst, i_val, i_abt, i_pc_plus_8, i_bstate,
    input  o_inst_ff, o_val_ff, o_abt_ff, o_pc_plus_8_ff, o_taken_ff,
           o_clear_from_decode, o_pc_from_decode
`ifdef ZAP_BRANCH_REDIRECT_STATS_EN
    , input o_redirect_count
`endif
  );

  modport slave (
    input  i_cpsr_t, i_inst, i_val, i_abt, i_pc_plus_8, i_bstate,
    output o_inst_ff, o_val_ff, o_abt_ff, o_pc_plus_8_ff, o_taken_ff,
           o_clear_from_decode, o_pc_from_decode
`ifdef ZAP_BRANCH_REDIRECT_STATS_EN
    , output o_redirect_count
`endif
  );
endinterface

// File: rtl/zap_branch_target_calc.sv
// Combinational ARM B/BL detector and PC-relative target adder.
module zap_branch_target_calc
  import zap_branch_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc_plus_8,
  output logic        is_branch,
  output logic [31:0] target
);
  logic [23:0] imm24;

  // The link bit does not change the redirect; the ALU handles the LR write.
  logic unused_link_bit;
  assign unused_link_bit = inst[24];

  assign imm24     = inst[23:0];
  assign is_branch = (inst[27:25] == BR_OPCODE) && (inst[31:28] != COND_NV);
  assign target    = pc_plus_8 + {{6{imm24[23]}}, imm24, 2'b00};
endmodule

// File: rtl/zap_branch_redirect.sv
// Pre-decode stage: predicts B/BL, redirects fetch early and registers the instruction.
// Optional: ZAP_BRANCH_REDIRECT_STATS_EN adds a saturating redirect counter.
module zap_branch_redirect
  import zap_branch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'd8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear_from_writeback,
  input  logic i_data_stall,
  input  logic i_clear_from_alu,
  input  logic i_stall_from_shifter,
  input  logic i_stall_from_issue,
  zap_branch_redirect_if.slave bus
);
  fsm_state_t  state;
  logic [31:0] inst_q, pc8_q, pcd_q;
  logic        val_q, abt_q, taken_q;

  logic        is_branch, predict_taken, clear_any, hold;
  logic [31:0] target;
  bstate_t     bstate;

  zap_branch_target_calc u_target_calc (
    .inst      (bus.i_inst),
    .pc_plus_8 (bus.i_pc_plus_8),
    .is_branch (is_branch),
    .target    (target)
  );

  assign bstate        = bstate_t'(bus.i_bstate);
  assign predict_taken = is_branch && bus.i_val && !bus.i_abt && !bus.i_cpsr_t &&
                         ((bus.i_inst[31:28] == COND_AL) || (bstate == WT) || (bstate == ST));

  // A data stall outranks the ALU clear, but not the writeback clear.
  assign clear_any = i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);
  assign hold      = i_data_stall || i_stall_from_shifter || i_stall_from_issue;

  // NOTE: every flop here is assigned with <= so all stage registers update
  // together from the same pre-edge values; '=' would make order matter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      inst_q  <= '0;
      val_q   <= 1'b0;
      abt_q   <= 1'b0;
      pc8_q   <= PC_RESET;
      taken_q <= 1'b0;
      pcd_q   <= '0;
      state   <= IDLE;
    end else if (clear_any) begin
      // A later-stage flush abandons any pending redirect; the target just holds.
      inst_q  <= '0;
      val_q   <= 1'b0;
      abt_q   <= 1'b0;
      pc8_q   <= PC_RESET;
      taken_q <= 1'b0;
      state   <= IDLE;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          inst_q  <= bus.i_inst;
          val_q   <= bus.i_val;
          abt_q   <= bus.i_abt;
          pc8_q   <= bus.i_pc_plus_8;
          taken_q <= predict_taken;
          if (predict_taken) begin
            pcd_q <= target;
            state <= REDIRECT;
          end
        end
        REDIRECT: begin
          // The slot behind a redirected branch is wrong-path; squash it.
          inst_q  <= '0;
          val_q   <= 1'b0;
          abt_q   <= 1'b0;
          pc8_q   <= bus.i_pc_plus_8;
          taken_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_inst_ff           = inst_q;
  assign bus.o_val_ff            = val_q;
  assign bus.o_abt_ff            = abt_q;
  assign bus.o_pc_plus_8_ff      = pc8_q;
  assign bus.o_taken_ff          = taken_q;
  assign bus.o_pc_from_decode    = pcd_q;
  assign bus.o_clear_from_decode = (state == REDIRECT);

`ifdef ZAP_BRANCH_REDIRECT_STATS_EN
  logic [31:0] redirect_count_q;
  logic        start_redirect;

  // Counts only real IDLE->REDIRECT transitions; flushes and stalls leave it alone.
  assign start_redirect = !clear_any && !hold && (state == IDLE) && predict_taken;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      redirect_count_q <= '0;
    else if (start_redirect && (redirect_count_q != 32'hFFFF_FFFF))
      redirect_count_q <= redirect_count_q + 32'd1;
  end

  assign bus.o_redirect_count = redirect_count_q;
`endif
endmodule

// File: tb/tb_zap_branch_redirect.sv
// Scoreboard bench for zap_branch_redirect: a behavioural model queues expected
// outputs per driven cycle; they are popped and compared one time unit after the edge.
module tb_zap_branch_redirect;
  logic i_clk, i_reset;
  logic i_clear_from_writeback, i_data_stall, i_clear_from_alu;
  logic i_stall_from_shifter, i_stall_from_issue;

  zap_branch_redirect_if bus ();

  zap_branch_redirect #(.PC_RESET(32'd8)) dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_stall_from_shifter   (i_stall_from_shifter),
    .i_stall_from_issue     (i_stall_from_issue),
    .bus                    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc8;
    logic [1:0]  bstate;
    logic        val, abt, t;
    logic        rst, cw, ds, ca, ss, si;
  } stim_t;

  typedef struct {
    logic [31:0] inst, pc8, pcd, cnt;
    logic        val, abt, taken, clr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [31:0] m_inst, m_pc8, m_pcd, m_cnt;
  logic        m_val, m_abt, m_taken, m_redirect;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, want);
  endtask

  function automatic stim_t mk(input logic [31:0] inst, input logic [31:0] pc8,
                               input logic [1:0] bs);
    stim_t s;
    s = '{default: '0};
    s.inst = inst; s.pc8 = pc8; s.bstate = bs; s.val = 1'b1;
    return s;
  endfunction

  task automatic model(input stim_t s);
    logic        br, tk;
    int          off;
    if (s.rst) begin
      m_inst = '0; m_val = 0; m_abt = 0; m_pc8 = 32'd8; m_taken = 0;
      m_pcd = '0; m_redirect = 0; m_cnt = '0;
    end else if (s.cw || (s.ca && !s.ds)) begin
      m_inst = '0; m_val = 0; m_abt = 0; m_pc8 = 32'd8; m_taken = 0; m_redirect = 0;
    end else if (s.ds || s.ss || s.si) begin
      // everything holds
    end else if (m_redirect) begin
      m_inst = '0; m_val = 0; m_abt = 0; m_taken = 0; m_pc8 = s.pc8; m_redirect = 0;
    end else begin
      br = (s.inst[27:25] == 3'b101) && (s.inst[31:28] != 4'hF);
      tk = br && s.val && !s.abt && !s.t && (s.inst[31:28] == 4'hE || s.bstate >= 2'd2);
      m_inst = s.inst; m_val = s.val; m_abt = s.abt; m_pc8 = s.pc8; m_taken = tk;
      if (tk) begin
        off = int'($signed(s.inst[23:0]));
        m_pcd = s.pc8 + 32'(off * 4);
        m_redirect = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    i_reset = s.rst; i_clear_from_writeback = s.cw; i_data_stall = s.ds;
    i_clear_from_alu = s.ca; i_stall_from_shifter = s.ss; i_stall_from_issue = s.si;
    bus.i_inst = s.inst; bus.i_pc_plus_8 = s.pc8; bus.i_bstate = s.bstate;
    bus.i_val = s.val; bus.i_abt = s.abt; bus.i_cpsr_t = s.t;
    model(s);
    exp_q.push_back('{inst: m_inst, pc8: m_pc8, pcd: m_pcd, cnt: m_cnt,
                      val: m_val, abt: m_abt, taken: m_taken, clr: m_redirect});
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("inst_ff",  bus.o_inst_ff,           e.inst);
      check("val_ff",   32'(bus.o_val_ff),        32'(e.val));
      check("abt_ff",   32'(bus.o_abt_ff),        32'(e.abt));
      check("pc8_ff",   bus.o_pc_plus_8_ff,      e.pc8);
      check("taken_ff", 32'(bus.o_taken_ff),      32'(e.taken));
      check("clear",    32'(bus.o_clear_from_decode), 32'(e.clr));
      check("pc_dec",   bus.o_pc_from_decode,    e.pcd);
`ifdef ZAP_BRANCH_REDIRECT_STATS_EN
      check("rd_count", bus.o_redirect_count,    e.cnt);
`endif
    end
  endtask

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  initial begin
    stim_t s;

    // Reset
    s = mk(NOP, 32'h0, 2'd0); s.val = 1'b0; s.rst = 1'b1;
    step(s); step(s);
    check("rst_pc8",   bus.o_pc_plus_8_ff, 32'd8);
    check("rst_clear", 32'(bus.o_clear_from_decode), 32'd0);

    // Taken AL branch, then a dropped wrong-path slot
    step(mk(32'hEA00_0002, 32'h108, 2'd0));
    check("al_clear",  32'(bus.o_clear_from_decode), 32'd1);
    check("al_target", bus.o_pc_from_decode, 32'h110);
    check("al_taken",  32'(bus.o_taken_ff), 32'd1);
    step(mk(NOP, 32'h10C, 2'd0));
    check("al_drop_clear", 32'(bus.o_clear_from_decode), 32'd0);
    check("al_drop_val",   32'(bus.o_val_ff), 32'd0);

    // Backward conditional branch: weakly taken vs weakly not taken
    step(mk(32'h0AFF_FFFE, 32'h108, 2'd2));
    check("bk_target", bus.o_pc_from_decode, 32'h100);
    step(mk(NOP, 32'h104, 2'd0));
    step(mk(32'h0AFF_FFFE, 32'h108, 2'd1));
    check("bk_nt_clear", 32'(bus.o_clear_from_decode), 32'd0);
    check("bk_nt_inst",  bus.o_inst_ff, 32'h0AFF_FFFE);

    // Target wraparound
    step(mk(32'hEAFF_FFFD, 32'h4, 2'd0));
    check("wrap_target", bus.o_pc_from_decode, 32'hFFFF_FFF8);
    step(mk(NOP, 32'h8, 2'd0));

    // Stall while redirecting: clear held for four sampled cycles
    step(mk(32'hEA00_0002, 32'h108, 2'd0));
    for (int i = 0; i < 3; i++) begin
      s = mk(NOP, 32'h10C, 2'd0); s.si = 1'b1;
      step(s);
      check("stall_clear",  32'(bus.o_clear_from_decode), 32'd1);
      check("stall_target", bus.o_pc_from_decode, 32'h110);
    end
    step(mk(NOP, 32'h10C, 2'd0));
    check("stall_release", 32'(bus.o_clear_from_decode), 32'd0);

    // Abort / Thumb never redirect; condition NV is not a branch
    s = mk(32'hEA00_0002, 32'h108, 2'd3); s.abt = 1'b1; step(s);
    check("abt_taken", 32'(bus.o_taken_ff), 32'd0);
    s = mk(32'hEA00_0002, 32'h108, 2'd3); s.t = 1'b1;   step(s);
    check("thumb_clear", 32'(bus.o_clear_from_decode), 32'd0);
    step(mk(32'hFA00_0002, 32'h108, 2'd3));

    // ALU clear during REDIRECT abandons it
    step(mk(32'hEA00_0002, 32'h200, 2'd0));
    s = mk(NOP, 32'h204, 2'd0); s.ca = 1'b1; step(s);
    check("alu_clr_clear", 32'(bus.o_clear_from_decode), 32'd0);
    check("alu_clr_pc8",   bus.o_pc_plus_8_ff, 32'd8);
    check("alu_clr_hold",  bus.o_pc_from_decode, 32'h208);

    // Data stall outranks the ALU clear; writeback clear outranks data stall
    step(mk(32'hEA00_0010, 32'h300, 2'd0));
    s = mk(NOP, 32'h304, 2'd0); s.ds = 1'b1; s.ca = 1'b1; step(s);
    s = mk(NOP, 32'h304, 2'd0); s.ds = 1'b1; s.cw = 1'b1; step(s);

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 2) != 0) r[27:25] = 3'b101;
      s = mk(r, $urandom, 2'($urandom_range(0, 3)));
      s.val = ($urandom_range(0, 5) != 0);
      s.abt = ($urandom_range(0, 7) == 0);
      s.t   = ($urandom_range(0, 7) == 0);
      s.cw  = ($urandom_range(0, 15) == 0);
      s.ds  = ($urandom_range(0, 9) == 0);
      s.ca  = ($urandom_range(0, 9) == 0);
      s.ss  = ($urandom_range(0, 9) == 0);
      s.si  = ($urandom_range(0, 9) == 0);
      step(s);
    end

    // Redirect counter: three redirects then reset
    s = mk(NOP, 32'h0, 2'd0); s.rst = 1'b1; step(s);
    for (int i = 0; i < 3; i++) begin
      step(mk(32'hEB00_0004, 32'h400 + 32'(i * 16), 2'd0));
      step(mk(NOP, 32'h404, 2'd0));
    end
`ifdef ZAP_BRANCH_REDIRECT_STATS_EN
    check("count_three", bus.o_redirect_count, 32'd3);
`endif
    s = mk(NOP, 32'h0, 2'd0); s.rst = 1'b1; step(s);
`ifdef ZAP_BRANCH_REDIRECT_STATS_EN
    check("count_reset", bus.o_redirect_count, 32'd0);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/zap_branch_redirect.md
Name: zap_branch_redirect

Overview:
- Pre-decode stage directly downstream of the branch predictor; consumes its instruction, valid, abort, PC+8 and 2-bit branch state.
- Detects ARM B/BL instructions, decides a static/dynamic prediction, computes the branch target and redirects fetch early via a clear-from-decode pulse with the new PC.
- Registers instruction fields plus the prediction bit toward decode/ALU, so the ALU can later confirm or clear.

Parameters:
- PC_RESET, 32'd8, o_pc_plus_8_ff value on reset/clear.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clear_from_writeback  in  1  flush (highest priority after reset).
- i_data_stall  in  1  hold all state.
- i_clear_from_alu  in  1  flush.
- i_stall_from_shifter  in  1  hold.
- i_stall_from_issue  in  1  hold.
- i_cpsr_t  in  1  Thumb state; 1 = never redirect.
- i_inst  in  32  instruction from predictor stage.
- i_val  in  1  instruction valid.
- i_abt  in  1  instruction abort.
- i_pc_plus_8  in  32  PC+8 of i_inst.
- i_bstate  in  2  predictor counter: 0 SNT, 1 WNT, 2 WT, 3 ST.
- o_inst_ff  out  32  registered instruction.
- o_val_ff  out  1  registered valid.
- o_abt_ff  out  1  registered abort.
- o_pc_plus_8_ff  out  32  registered PC+8.
- o_taken_ff  out  1  1 = this instruction was predicted taken and redirected.
- o_clear_from_decode  out  1  redirect request to predictor/fetch.
- o_pc_from_decode  out  32  redirect target, valid while o_clear_from_decode=1.

Behaviour:
- Reset: o_inst_ff=0, o_val_ff=0, o_abt_ff=0, o_pc_plus_8_ff=PC_RESET, o_taken_ff=0, o_pc_from_decode=0, FSM=IDLE, o_clear_from_decode=0.
- Priority per edge: reset > clear_from_writeback > data_stall > clear_from_alu > stall_from_shifter > stall_from_issue > normal. Clears load the reset values, except o_pc_from_decode, which holds; FSM goes to IDLE. Stalls hold every flop, FSM included.
- Branch detect: i_inst[27:25]==3'b101 and i_inst[31:28]!=4'b1111.
- Predict taken: detect and i_val and !i_abt and !i_cpsr_t and (cond==4'b1110, or i_bstate[1]==1).
- Target: i_pc_plus_8 + {{6{imm24[23]}}, imm24, 2'b00}, modulo 2^32 with wraparound.
- FSM IDLE, normal update:
  - register i_inst/i_val/i_abt/i_pc_plus_8;
  - o_taken_ff = predict taken;
  - if taken: o_pc_from_decode <= target, FSM -> REDIRECT.
- o_clear_from_decode = (FSM==REDIRECT), driven directly from the state flop. Latency: 1 cycle after the branch is accepted.
- FSM REDIRECT, normal update:
  - the incoming instruction is wrong-path and is dropped: o_val_ff<=0, o_abt_ff<=0, o_taken_ff<=0, o_inst_ff<=0;
  - FSM -> IDLE; no new redirect can be issued in this cycle.
- REDIRECT under any stall: clear stays asserted and the target is held. The pulse therefore lasts until the first unstalled cycle.
- REDIRECT with a clear from writeback or ALU: FSM -> IDLE and the redirect is abandoned, because the later-stage clear wins.
- Aborted instructions, invalid slots and Thumb-mode instructions never redirect; o_taken_ff=0.
- BL is redirected identically; the link write is left to the ALU.

Optional Feature:
- Macro ZAP_BRANCH_REDIRECT_STATS_EN.
- Defined: adds output o_redirect_count[31:0], which increments on every IDLE->REDIRECT transition and saturates at 32'hFFFFFFFF. Reset clears it; clears and stalls do not.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package zap_branch_pkg: SNT/WNT/WT/ST encodings, COND_AL=4'b1110, COND_NV=4'b1111, branch opcode field value 3'b101, FSM encodings IDLE/REDIRECT.
- One combinational sub-module, zap_branch_target_calc: inputs inst and pc_plus_8; outputs is_branch and target.

Test Plan:
- Taken AL branch: inst 32'hEA000002, pc_plus_8 32'h108, bstate 0, val 1 -> next cycle o_clear_from_decode=1, o_pc_from_decode=32'h110, o_taken_ff=1; the following cycle clear=0 and the wrong-path input is dropped (o_val_ff=0).
- Backward conditional branch: inst 32'h0AFFFFFE, pc_plus_8 32'h108. With bstate 2 -> target 32'h100, taken. Repeat with bstate 1 -> no clear, o_taken_ff=0, instruction passed through.
- Wraparound: inst 32'hEAFFFFFD, pc_plus_8 32'h4 -> o_pc_from_decode=32'hFFFFFFF8.
- Stall in REDIRECT: assert i_stall_from_issue for 3 cycles after the redirect -> clear held high for 4 cycles with a stable target; it drops after the first unstalled edge.
- Abort, Thumb and clear: i_abt=1 or i_cpsr_t=1 on 32'hEA000002 -> no redirect. i_clear_from_alu in the REDIRECT cycle -> FSM IDLE, o_val_ff=0, o_pc_plus_8_ff=8.
- Stats (macro on): 3 redirects, then i_reset -> o_redirect_count goes 0,1,2,3, then 0.
